// File: rtl/pkg_condicionador.sv
// pkg_condicionador: shared FSM state type, default timing constants and counter sizing for the button conditioner.
package pkg_condicionador;

    typedef enum logic [1:0] {
        SOLTO          = 2'b00,
        CONFIRMA_PRESS = 2'b01,
        PRESSIONADO    = 2'b10,
        CONFIRMA_SOLTO = 2'b11
    } estado_t;

    localparam int DEB_CYCLES_DEF    = 1000000;
    localparam int REPEAT_CYCLES_DEF = 25000000;

    function automatic int cnt_width(input int deb, input int rep);
        int m;
        m = (deb > rep) ? deb : rep;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DEB_CYCLES_DEF, REPEAT_CYCLES_DEF);

endpackage

// File: rtl/modulo_debounce_canal.sv
// modulo_debounce_canal: one button channel (sync, debounce FSM, pulse).
// Auto-repeat while held is built only when CONDICIONADOR_REPEAT_EN is defined.
module modulo_debounce_canal
    import pkg_condicionador::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic Nclr,
    input  logic Nkey,
    output logic level,
    output logic pulse
);

    localparam int CW = cnt_width(DEB_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [1:0]    sync_ff;
    logic          key;
    estado_t       state, state_nxt;
    logic [CW-1:0] cnt, cnt_inc;
    logic          pulse_q, press_ok, rep_hit, counting;

    always_ff @(posedge clk or negedge Nclr)
        if (!Nclr) sync_ff <= '0;
        else       sync_ff <= {sync_ff[0], ~Nkey};

    assign key = sync_ff[1];

    always_ff @(posedge clk or negedge Nclr)
        if (!Nclr) state <= SOLTO;
        else       state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            SOLTO:          state_nxt = key ? CONFIRMA_PRESS : SOLTO;
            CONFIRMA_PRESS: state_nxt = !key ? SOLTO : (cnt == DEB_LAST ? PRESSIONADO : CONFIRMA_PRESS);
            PRESSIONADO:    state_nxt = key ? PRESSIONADO : CONFIRMA_SOLTO;
            CONFIRMA_SOLTO: state_nxt = key ? PRESSIONADO : (cnt == DEB_LAST ? SOLTO : CONFIRMA_SOLTO);
            default:        state_nxt = SOLTO;
        endcase
    end

    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign press_ok = (state == CONFIRMA_PRESS) && (state_nxt == PRESSIONADO);

`ifdef CONDICIONADOR_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
    // In PRESSIONADO the same counter times the repeat period
    assign counting = (state != SOLTO);
    assign rep_hit  = (state == PRESSIONADO) && (state_nxt == PRESSIONADO) && (cnt == REP_LAST);
`else
    assign counting = (state == CONFIRMA_PRESS) || (state == CONFIRMA_SOLTO);
    assign rep_hit  = 1'b0;
`endif

    always_ff @(posedge clk or negedge Nclr)
        if (!Nclr) begin
            cnt     <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt     <= (state != state_nxt || rep_hit || !counting) ? '0 : cnt_inc;
            pulse_q <= press_ok | rep_hit;
        end

    always_comb begin
        level = (state == PRESSIONADO) || (state == CONFIRMA_SOLTO);
        pulse = pulse_q;
    end

endmodule

// File: rtl/modulo_condicionador_botoes.sv
// modulo_condicionador_botoes: two independent debounced pushbutton channels (cork entry, load confirm).
// Define CONDICIONADOR_REPEAT_EN to get auto-repeat pulses while a button is held.
module modulo_condicionador_botoes
    import pkg_condicionador::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic Nclr,
    input  logic Nkey_c,
    input  logic Nkey_op,
    output logic op_c_deboucing,
    output logic op_deboucing,
    output logic op_c_pulso,
    output logic op_pulso
);

    modulo_debounce_canal #(
        .DEB_CYCLES   (DEB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_canal_c (
        .clk  (clk),
        .Nclr (Nclr),
        .Nkey (Nkey_c),
        .level(op_c_deboucing),
        .pulse(op_c_pulso)
    );

    modulo_debounce_canal #(
        .DEB_CYCLES   (DEB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_canal_op (
        .clk  (clk),
        .Nclr (Nclr),
        .Nkey (Nkey_op),
        .level(op_deboucing),
        .pulse(op_pulso)
    );

endmodule

// File: tb/tb_modulo_condicionador_botoes.sv
// tb_modulo_condicionador_botoes: scoreboard bench; a run-length reference model predicts levels and pulse cycles.
module tb_modulo_condicionador_botoes;

    localparam int DEB = 4;
    localparam int REP = 10;
`ifdef CONDICIONADOR_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic Nclr, Nkey_c, Nkey_op;
    logic op_c_deboucing, op_deboucing, op_c_pulso, op_pulso;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int qc[$];
    int qo[$];

    bit m_d1[2], m_d2[2], m_lvl[2], m_prev[2];
    int m_run[2], m_hold[2];

    int npulse[2], nrise[2], first_pulse[2], last_pulse[2], rise[2], fall[2];
    logic lv_prev[2];

    modulo_condicionador_botoes #(
        .DEB_CYCLES   (DEB),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk           (clk),
        .Nclr          (Nclr),
        .Nkey_c        (Nkey_c),
        .Nkey_op       (Nkey_op),
        .op_c_deboucing(op_c_deboucing),
        .op_deboucing  (op_deboucing),
        .op_c_pulso    (op_c_pulso),
        .op_pulso      (op_pulso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int qsize(input int ch);
        return (ch == 0) ? qc.size() : qo.size();
    endfunction

    function automatic int qfront(input int ch);
        return (ch == 0) ? qc[0] : qo[0];
    endfunction

    function automatic int qpop(input int ch);
        if (ch == 0) return qc.pop_front();
        return qo.pop_front();
    endfunction

    // Reference: a level flips after DEB+1 consecutive synchronized samples that disagree with it;
    // with repeat, every REP consecutive held samples after the rise (or a bounce back) yields a pulse.
    always @(posedge clk) begin
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            bit p, s, flipped;
            p = (ch == 0) ? !Nkey_c : !Nkey_op;
            flipped = 1'b0;
            if (!Nclr) begin
                m_d1[ch] = 0; m_d2[ch] = 0; m_lvl[ch] = 0; m_prev[ch] = 0;
                m_run[ch] = 0; m_hold[ch] = 0;
            end else begin
                s = m_d2[ch];
                m_d2[ch] = m_d1[ch];
                m_d1[ch] = p;
                if (s != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DEB + 1) begin
                        m_lvl[ch] = s;
                        m_run[ch] = 0;
                        m_hold[ch] = 0;
                        flipped = 1'b1;
                        if (s) begin
                            if (ch == 0) qc.push_back(cyc); else qo.push_back(cyc);
                        end
                    end
                end else m_run[ch] = 0;
                if (m_lvl[ch] && s && !flipped) begin
                    m_hold[ch] = m_prev[ch] ? m_hold[ch] + 1 : 0;
                    if (REP_EN && m_hold[ch] == REP) begin
                        m_hold[ch] = 0;
                        if (ch == 0) qc.push_back(cyc); else qo.push_back(cyc);
                    end
                end
                m_prev[ch] = s;
            end
        end
    end

    task automatic mon(input int ch, input logic lv, input logic pu);
        chk(ch == 0 ? "c_level" : "op_level", int'(lv), int'(m_lvl[ch]));
        if (lv && !lv_prev[ch]) begin rise[ch] = cyc; nrise[ch]++; end
        if (!lv && lv_prev[ch]) fall[ch] = cyc;
        lv_prev[ch] = lv;
        if (pu) begin
            npulse[ch]++;
            last_pulse[ch] = cyc;
            if (first_pulse[ch] < 0) first_pulse[ch] = cyc;
            chk(ch == 0 ? "c_pulse_pending" : "op_pulse_pending", int'(qsize(ch) > 0), 1);
            if (qsize(ch) > 0) chk(ch == 0 ? "c_pulse_cycle" : "op_pulse_cycle", cyc, qpop(ch));
        end else if (qsize(ch) > 0) begin
            chk(ch == 0 ? "c_pulse_missing" : "op_pulse_missing", int'(qfront(ch) > cyc), 1);
            if (qfront(ch) <= cyc) void'(qpop(ch));
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, op_c_deboucing, op_c_pulso);
        mon(1, op_deboucing, op_pulso);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_marks();
        for (int ch = 0; ch < 2; ch++) first_pulse[ch] = -1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_c_lvl"}, int'(op_c_deboucing), 0);
        chk({name, "_op_lvl"}, int'(op_deboucing), 0);
        chk({name, "_c_pul"}, int'(op_c_pulso), 0);
        chk({name, "_op_pul"}, int'(op_pulso), 0);
    endtask

    initial begin
        int t0, t1, tr, n0, n1, r1;
        for (int ch = 0; ch < 2; ch++) begin
            npulse[ch] = 0; nrise[ch] = 0; first_pulse[ch] = -1; last_pulse[ch] = -1;
            rise[ch] = -1; fall[ch] = -1; lv_prev[ch] = 1'b0;
        end
        Nclr = 1'b0; Nkey_c = 1'b1; Nkey_op = 1'b1;
        tick(3);
        #1 chk_all_zero("reset");
        @(negedge clk) Nclr = 1'b1;
        tick(4);

        // clean press on the cork-entry key
        clr_marks(); n0 = npulse[0];
        @(negedge clk) Nkey_c = 1'b0; t0 = cyc + 1;
        tick(20);
        Nkey_c = 1'b1; t1 = cyc + 1;
        tick(12);
        chk("clean_rise", rise[0] - t0, DEB + 2);
        chk("clean_pulse", first_pulse[0] - t0, DEB + 2);
        chk("clean_fall", fall[0] - t1, DEB + 2);
        chk("clean_npulse", npulse[0] - n0, REP_EN ? 2 : 1);

        // bounce on the load-confirm key
        n1 = npulse[1]; r1 = nrise[1];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) Nkey_op = 1'b0;
            tick(1);
            Nkey_op = 1'b1;
            tick(1);
        end
        tick(12);
        chk("bounce_npulse", npulse[1] - n1, 0);
        chk("bounce_nrise", nrise[1] - r1, 0);

        // simultaneous press
        clr_marks();
        @(negedge clk) begin Nkey_c = 1'b0; Nkey_op = 1'b0; end
        t0 = cyc + 1;
        tick(8);
        Nkey_c = 1'b1; Nkey_op = 1'b1;
        tick(12);
        chk("simul_c_pulse", first_pulse[0] - t0, DEB + 2);
        chk("simul_op_pulse", first_pulse[1] - t0, DEB + 2);

        // reset mid-qualification, key kept low
        n0 = npulse[0];
        @(negedge clk) Nkey_c = 1'b0;
        tick(3);
        Nclr = 1'b0;
        #1 chk_all_zero("midrst");
        tick(2);
        clr_marks();
        Nclr = 1'b1; tr = cyc + 1;
        tick(10);
        chk("midrst_pulse", first_pulse[0] - tr, DEB + 2);
        chk("midrst_npulse", npulse[0] - n0, 1);

        // reset while pressed drops the level at once
        Nclr = 1'b0;
        #1 chk("held_rst_lvl", int'(op_c_deboucing), 0);
        tick(2);
        Nclr = 1'b1;
        tick(2);
        Nkey_c = 1'b1;
        tick(12);

        // long hold
        clr_marks(); n0 = npulse[0];
        @(negedge clk) Nkey_c = 1'b0; t0 = cyc + 1;
        tick(40);
        Nkey_c = 1'b1;
        tick(12);
        chk("hold_npulse", npulse[0] - n0, REP_EN ? 4 : 1);
        chk("hold_first", first_pulse[0] - t0, DEB + 2);
        chk("hold_last", last_pulse[0] - t0, REP_EN ? DEB + 2 + 3 * REP : DEB + 2);

        // random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) Nkey_c = ~Nkey_c;
            if ($urandom_range(0, 5) == 0) Nkey_op = ~Nkey_op;
            Nclr = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk) begin Nclr = 1'b1; Nkey_c = 1'b1; Nkey_op = 1'b1; end
        tick(20);
        chk("queues_drained", qc.size() + qo.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
